// File: rtl/memcache_pkg.sv
// Shared definitions for the memcache key-hash path (packer and hasher).
package memcache_pkg;

  localparam int KEY_WORDS     = 3;
  localparam int KEY_BYTES_MAX = 12;

  // Length presented to the hasher when no key is on the bus.
  localparam logic [7:0] KEY_LEN_IDLE = 8'd0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    DRAIN = 2'd2,
    GAP   = 2'd3
  } pk_state_t;

endpackage

// File: rtl/sat_counter16.sv
// 16-bit event counter that sticks at 0xFFFF instead of wrapping.
module sat_counter16 (
  input  logic        CLK,
  input  logic        RST,
  input  logic        inc,
  output logic [15:0] count
);

  // Count one event per cycle when inc is high, holding at all-ones.
  always_ff @(posedge CLK) begin
    if (RST) begin
      count <= 16'd0;
    end else if (inc && (count != 16'hFFFF)) begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/memcache_key_packer.sv
// Packs a byte-serial memcache key into three big-endian 32-bit words and
// presents it to the hasher for one cycle. Oversize keys are drained and
// dropped. Handshake: a byte moves on a rising edge where key_valid and
// key_ready are both high; the source holds key_data/key_last stable until
// then, and key_ready never depends combinationally on key_valid.
module memcache_key_packer
  import memcache_pkg::*;
#(
  parameter int MAX_BYTES = 12,
  parameter int ISSUE_GAP = 0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        key_valid,
  input  logic [7:0]  key_data,
  input  logic        key_last,
  output logic        key_ready,
  output logic        out_valid,
  output logic [7:0]  key_length,
  output logic [31:0] k0,
  output logic [31:0] k1,
  output logic [31:0] k2,
  output logic        err_oversize,
  output logic [15:0] issue_count,
  output logic [15:0] drop_count,
  output pk_state_t   state
);

  localparam logic [7:0] MAX_B     = 8'(MAX_BYTES);
  localparam logic [7:0] DRAIN_CNT = 8'(MAX_BYTES + 1);
  localparam logic [15:0] GAP_LOAD = 16'(ISSUE_GAP - 1);

  logic [7:0]  cnt;
  logic [95:0] acc;
  logic [15:0] gap_cnt;

  logic        accept;
  logic        fits;
  logic        do_issue;
  logic        do_drop;
  logic [95:0] lane_byte;
  logic [95:0] merged;

  // Place the incoming byte in its big-endian lane and merge with held bytes.
  always_comb begin
    accept    = key_valid & key_ready;
    fits      = (cnt < MAX_B);
    lane_byte = {key_data, 88'd0} >> {cnt, 3'b000};
    merged    = acc | lane_byte;
    do_issue  = accept & key_last & (state != DRAIN) & fits;
    do_drop   = accept & key_last & ((state == DRAIN) | ~fits);
  end

  // Key state machine with registered hasher-side outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= IDLE;
      cnt          <= 8'd0;
      acc          <= 96'd0;
      gap_cnt      <= 16'd0;
      key_ready    <= 1'b0;
      out_valid    <= 1'b0;
      key_length   <= KEY_LEN_IDLE;
      k0           <= 32'd0;
      k1           <= 32'd0;
      k2           <= 32'd0;
      err_oversize <= 1'b0;
    end else begin
      out_valid    <= 1'b0;
      key_length   <= KEY_LEN_IDLE;
      k0           <= 32'd0;
      k1           <= 32'd0;
      k2           <= 32'd0;
      err_oversize <= do_drop;
      key_ready    <= 1'b1;

      if (do_issue) begin
        out_valid  <= 1'b1;
        key_length <= 8'(cnt + 8'd1);
        k0         <= merged[95:64];
        k1         <= merged[63:32];
        k2         <= merged[31:0];
      end

      case (state)
        IDLE, ACC, DRAIN: begin
          if (accept) begin
            if (key_last) begin
              acc <= 96'd0;
              cnt <= 8'd0;
              if (ISSUE_GAP > 0) begin
                state     <= GAP;
                gap_cnt   <= GAP_LOAD;
                key_ready <= 1'b0;
              end else begin
                state <= IDLE;
              end
            end else if (state != DRAIN) begin
              if (fits) begin
                acc   <= merged;
                cnt   <= 8'(cnt + 8'd1);
                state <= ACC;
              end else begin
                acc   <= 96'd0;
                cnt   <= DRAIN_CNT;
                state <= DRAIN;
              end
            end
          end
        end
        GAP: begin
          if (gap_cnt == 16'd0) begin
            state <= IDLE;
          end else begin
            gap_cnt   <= gap_cnt - 16'd1;
            key_ready <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  sat_counter16 u_issue_count (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (do_issue),
    .count (issue_count)
  );

  sat_counter16 u_drop_count (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (do_drop),
    .count (drop_count)
  );

endmodule

// File: tb/tb_memcache_key_packer.sv
// Bench for memcache_key_packer: random and directed keys against a
// byte-list reference model, scoreboard-checked by a negedge monitor.
module tb_memcache_key_packer;
  import memcache_pkg::*;

  localparam int MAXB = 12;
  localparam int W    = 106;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // ---------------- DUT with ISSUE_GAP = 0 ----------------
  logic        key_valid = 1'b0;
  logic [7:0]  key_data  = 8'd0;
  logic        key_last  = 1'b0;
  logic        key_ready, out_valid, err_oversize;
  logic [7:0]  key_length;
  logic [31:0] k0, k1, k2;
  logic [15:0] issue_count, drop_count;
  pk_state_t   state;

  memcache_key_packer #(.MAX_BYTES(MAXB), .ISSUE_GAP(0)) dut (
    .CLK(CLK), .RST(RST), .key_valid(key_valid), .key_data(key_data),
    .key_last(key_last), .key_ready(key_ready), .out_valid(out_valid),
    .key_length(key_length), .k0(k0), .k1(k1), .k2(k2),
    .err_oversize(err_oversize), .issue_count(issue_count),
    .drop_count(drop_count), .state(state)
  );

  // ---------------- DUT with ISSUE_GAP = 2 ----------------
  logic        v2 = 1'b0;
  logic [7:0]  d2 = 8'd0;
  logic        l2 = 1'b0;
  logic        ready2, ov2, err2;
  logic [7:0]  len2;
  logic [31:0] a2, b2, c2;
  logic [15:0] ic2, dc2;
  pk_state_t   state2;

  memcache_key_packer #(.MAX_BYTES(MAXB), .ISSUE_GAP(2)) dut_gap (
    .CLK(CLK), .RST(RST), .key_valid(v2), .key_data(d2),
    .key_last(l2), .key_ready(ready2), .out_valid(ov2),
    .key_length(len2), .k0(a2), .k1(b2), .k2(c2),
    .err_oversize(err2), .issue_count(ic2),
    .drop_count(dc2), .state(state2)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] exp_q[$];
  int exp_issue = 0;
  int exp_drop  = 0;
  logic [7:0] cur_key[$];
  bit bubbles_on = 1'b0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference: a key of n bytes is issued if n <= MAXB, byte i landing in
  // word i/4 with byte 0 most significant; otherwise it is dropped.
  function automatic logic [W-1:0] expect_key();
    logic [31:0] w[3];
    int n;
    n = cur_key.size();
    if (n > MAXB) return {1'b0, 1'b1, 8'd0, 96'd0};
    for (int j = 0; j < 3; j++) w[j] = 32'd0;
    for (int i = 0; i < n; i++) w[i / 4][31 - 8 * (i % 4) -: 8] = cur_key[i];
    return {1'b1, 1'b0, 8'(n), w[0], w[1], w[2]};
  endfunction

  // Monitor: pop one expectation per output event, otherwise require idle bus.
  always @(negedge CLK) begin
    logic [W-1:0] e;
    if (!RST) begin
      if (out_valid || err_oversize) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", {out_valid, err_oversize, key_length}, 0);
        end else begin
          e = exp_q.pop_front();
          check("key_output", {out_valid, err_oversize, key_length, k0, k1, k2}, e);
          if (e[W-1]) exp_issue = (exp_issue < 65535) ? exp_issue + 1 : 65535;
          else        exp_drop  = (exp_drop  < 65535) ? exp_drop  + 1 : 65535;
          check("issue_count", issue_count, exp_issue);
          check("drop_count", drop_count, exp_drop);
        end
      end else begin
        check("idle_bus", {key_length, k0, k1, k2}, 0);
      end
    end
  end

  // Gap-DUT monitor: record cycle and contents of each strobe.
  int          ov2_t[$];
  logic [39:0] ov2_v[$];
  always @(negedge CLK) begin
    if (!RST && ov2) begin
      ov2_t.push_back(cyc);
      ov2_v.push_back({len2, a2});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_byte(input logic [7:0] b, input logic last);
    int guard;
    @(negedge CLK);
    if (bubbles_on && $urandom_range(0, 3) == 0) begin
      key_valid = 1'b0;
      @(negedge CLK);
    end
    key_valid = 1'b1;
    key_data  = b;
    key_last  = last;
    guard = 0;
    while (!key_ready && guard < 50) begin
      @(negedge CLK);
      guard++;
    end
    if (guard >= 50) check("ready_timeout", 0, 1);
    @(posedge CLK);
  endtask

  task automatic idle_cycle();
    @(negedge CLK);
    key_valid = 1'b0;
    key_last  = 1'b0;
  endtask

  task automatic send_cur_key();
    exp_q.push_back(expect_key());
    for (int i = 0; i < cur_key.size(); i++)
      drive_byte(cur_key[i], (i == cur_key.size() - 1));
  endtask

  task automatic set_key(input string s);
    cur_key.delete();
    for (int i = 0; i < s.len(); i++) cur_key.push_back(s[i]);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, key_ready, 0);
    check({tag, "_outs"}, {out_valid, err_oversize, key_length, k0, k1, k2}, 0);
    check({tag, "_counts"}, {issue_count, drop_count}, 0);
    check({tag, "_state"}, state, IDLE);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "timeout");
  end

  // ---------------- main sequence ----------------
  initial begin
    int lowcnt;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_reset_outputs("reset");
    RST = 1'b0;
    @(posedge CLK);
    #1;
    check("ready_after_reset", key_ready, 1);

    // Reset mid-key: three bytes of "abcdefg" then reset.
    drive_byte("a", 1'b0);
    drive_byte("b", 1'b0);
    drive_byte("c", 1'b0);
    @(negedge CLK);
    key_valid = 1'b0;
    RST = 1'b1;
    @(negedge CLK);
    check_reset_outputs("midkey_reset");
    RST = 1'b0;
    set_key("qr");            send_cur_key();
    idle_cycle();

    // Directed keys from the test plan.
    set_key("abcdefghijkl");  send_cur_key();
    set_key("abcde");         send_cur_key();
    set_key("abcdefghijklm"); send_cur_key();
    set_key("z");             send_cur_key();
    set_key("a");             send_cur_key();
    set_key("abcdefghijklmn"); send_cur_key();
    idle_cycle();
    idle_cycle();

    // Random keys, with and without handshake bubbles.
    bubbles_on = 1'b1;
    for (int k = 0; k < 80; k++) begin
      cur_key.delete();
      for (int i = 0; i < int'($urandom_range(1, 16)); i++)
        cur_key.push_back(8'($urandom_range(0, 255)));
      send_cur_key();
      if ($urandom_range(0, 4) == 0) idle_cycle();
    end
    bubbles_on = 1'b0;

    // Very long oversize key exercises the saturating byte counter.
    cur_key.delete();
    for (int i = 0; i < 300; i++) cur_key.push_back(8'($urandom_range(0, 255)));
    send_cur_key();
    set_key("k");             send_cur_key();
    idle_cycle();

    // ISSUE_GAP = 2: "x" then "y" offered back-to-back.
    @(negedge CLK);
    v2 = 1'b1; d2 = "x"; l2 = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    d2 = "y";
    lowcnt = 0;
    while (!ready2 && lowcnt < 10) begin
      lowcnt++;
      @(negedge CLK);
    end
    check("gap_ready_low_cycles", lowcnt, 2);
    @(posedge CLK);
    @(negedge CLK);
    v2 = 1'b0; l2 = 1'b0;
    repeat (3) @(negedge CLK);
    check("gap_pulse_count", ov2_t.size(), 2);
    if (ov2_t.size() == 2) begin
      check("gap_pulse_spacing", ov2_t[1] - ov2_t[0], 3);
      check("gap_key_x", ov2_v[0], {8'd1, 32'h7800_0000});
      check("gap_key_y", ov2_v[1], {8'd1, 32'h7900_0000});
    end
    check("gap_issue_count", ic2, 2);

    // Saturation: 65536 more one-byte keys back-to-back.
    for (int k = 0; k < 65536; k++) begin
      cur_key.delete();
      cur_key.push_back(8'($urandom_range(0, 255)));
      send_cur_key();
    end
    idle_cycle();
    repeat (3) @(negedge CLK);
    check("issue_count_saturated", issue_count, 16'hFFFF);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/memcache_key_packer.md
# memcache_key_packer

Front end of the memcache key-hash path. Accepts a key as a byte stream from the protocol parser and packs it into three 32-bit big-endian words plus a byte length. Presents them for one cycle on the hasher input (`key_length`, `k0`–`k2`). When idle it drives `key_length = 0` and zero words, which the hasher treats as "no key". Oversize keys are dropped and flagged. Issued and dropped keys are counted.

## Interface
Parameters:
- `MAX_BYTES`, default 12: longest key accepted; must be 1..12 (three words).
- `ISSUE_GAP`, default 0: idle cycles forced on `key_ready` after each key's last byte is accepted.

Ports (all outputs registered):
- `CLK` in 1: clock; all logic on posedge.
- `RST` in 1: reset, synchronous, active-high.
- `key_valid` in 1: byte on `key_data` is valid.
- `key_data` in 8: key byte, in order of arrival.
- `key_last` in 1: marks the final byte of the key; qualified by `key_valid`.
- `key_ready` out 1: a byte is accepted on an edge where `key_valid & key_ready`.
- `out_valid` out 1: one-cycle strobe; the packed key is on `key_length`, `k0`–`k2`.
- `key_length` out 8: key byte count 1..`MAX_BYTES` while `out_valid`; otherwise 0.
- `k0` out 32: key bytes 0–3. Byte 0 is in `[31:24]`.
- `k1` out 32: key bytes 4–7.
- `k2` out 32: key bytes 8–11.
- `err_oversize` out 1: one-cycle strobe when an oversize key completes.
- `issue_count` out 16: keys issued; saturates at 0xFFFF.
- `drop_count` out 16: keys dropped; saturates at 0xFFFF.

## Operation
States:
- IDLE: no partial key held.
- ACC: one or more bytes of the current key held.
- DRAIN: discarding the rest of an oversize key.
- GAP: enforced spacing after a key completes.

Transitions:
- IDLE → ACC on an accepted byte with `key_last = 0`.
- An accepted byte with `key_last = 1` in IDLE or ACC, with total bytes ≤ `MAX_BYTES`, issues the key.
  - Goes to GAP if `ISSUE_GAP > 0`, otherwise to IDLE.
- The accepted byte that makes the count `MAX_BYTES+1` moves to DRAIN.
  - If that byte is itself the last byte, it goes directly to the drop action and skips DRAIN.
- In DRAIN, bytes are accepted and discarded. The byte with `key_last` triggers the drop action:
  - `err_oversize` = 1 for one cycle;
  - `drop_count` += 1;
  - no `out_valid`;
  - then GAP (or IDLE if `ISSUE_GAP = 0`).
- GAP lasts exactly `ISSUE_GAP` cycles with `key_ready = 0`, then IDLE.

Packing:
- Byte n is written to word n/4, lane `[31-8*(n%4) -: 8]`.
- Lanes not written are 0. The accumulator is cleared on every issue or drop.

Issue:
- On the edge that accepts the last byte, load:
  - `k0`–`k2` = accumulator merged with the incoming byte;
  - `key_length` = byte count;
  - `out_valid` = 1;
  - `issue_count` += 1.
- On the next edge `out_valid`, `key_length`, `k0`, `k1` and `k2` return to 0, unless another key is issued on that same edge.

Byte counter:
- 8-bit counter, saturating at `MAX_BYTES+1`.
- Keys of any length up to 255+ bytes drain correctly.

Other rules:
- `key_ready` = 1 in IDLE, ACC and DRAIN; 0 in GAP and while `RST` is high.
- Reset mid-key: the partial key is discarded. No `out_valid`, `err_oversize` or count change results.
- When both counters update on the same edge, each updates independently.

## Timing
- Reset values: `key_ready` 0, `out_valid` 0, `key_length` 0, `k0`/`k1`/`k2` 0, `err_oversize` 0, `issue_count` 0, `drop_count` 0, state IDLE.
- `key_ready` rises on the first edge with `RST` low.
- Latency is 1 cycle: the outputs are valid in the cycle after the edge that accepts the last byte, and last exactly one cycle.
- With `ISSUE_GAP = 0`, throughput is one byte per cycle with no bubble between keys. A 1-byte key may follow a key immediately, giving `out_valid` on consecutive cycles.
- With `ISSUE_GAP = G`, the next key's first byte is accepted no earlier than G+1 edges after the previous key's last byte.
- `key_valid` held with `key_ready = 0` is not accepted. The source must hold its data stable until the byte is accepted.

## Structure
- Shared package `memcache_pkg` holds:
  - `KEY_WORDS = 3` and `KEY_BYTES_MAX = 12`;
  - the state enum `pk_state_t` (IDLE, ACC, DRAIN, GAP);
  - the idle length constant `KEY_LEN_IDLE = 8'd0`, also used by the hasher.
- Sub-module `sat_counter16`: a 16-bit saturating increment with synchronous reset, instantiated twice.
- The lane-insert and state-machine logic stay in the top module.

## Test plan
- "abcdefghijkl" (12 bytes, `key_last` on "l") → one cycle later:
  - `out_valid` = 1, `key_length` = 0x0C;
  - `k0` = 0x61626364, `k1` = 0x65666768, `k2` = 0x696A6B6C;
  - `issue_count` = 1.
- "abcde" → `key_length` = 5, `k0` = 0x61626364, `k1` = 0x65000000, `k2` = 0. Next cycle all outputs return to 0.
- 13-byte key "abcdefghijklm" → no `out_valid`. `err_oversize` pulses once, on the cycle after "m" is accepted, and `drop_count` = 1. An immediately following "z" then gives `key_length` = 1 and `k0` = 0x7A000000.
- `ISSUE_GAP` = 2, two 1-byte keys "x","y" offered back-to-back:
  - `key_ready` is low for exactly 2 cycles after "x" is accepted;
  - the two `out_valid` pulses are 3 cycles apart.
- `RST` asserted after 3 bytes of "abcdefg", then released:
  - all outputs are 0 and `key_ready` is 0 during reset;
  - the next key "qr" gives `key_length` = 2 and `k0` = 0x71720000, with no residue from the aborted key.
- Counter saturation: force 65536 one-byte keys → `issue_count` holds at 0xFFFF.
